// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register with hold, shift right, shift left and parallel load.
// The register drives the parallel output directly, so there is no input-to-output combinational path.
module universal_shift_register #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       sel,
    input  logic             sinr,
    input  logic             sinl,
    output logic [WIDTH-1:0] out
);

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_SHR   = 2'b01;
    localparam logic [1:0] SEL_SHL   = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;

    // Next-value selection; serial bits enter at the end opposite the discarded bit.
    always_comb begin
        w_q_next = r_q;
        case (sel)
            SEL_HOLD: w_q_next = r_q;
            SEL_SHR:  w_q_next = {sinr, r_q[WIDTH-1:1]};
            SEL_SHL:  w_q_next = {r_q[WIDTH-2:0], sinl};
            SEL_LOAD: w_q_next = in;
            default:  w_q_next = r_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign out = r_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench: directed test-plan vectors with literal expectations, then random
// operations checked every cycle against an arithmetic model of the register.
module tb_universal_shift_register;

    localparam int unsigned W    = 4;
    localparam int          MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] in_d = '0;
    logic [1:0]   sel = 2'b00;
    logic         sinr = 1'b0;
    logic         sinl = 1'b0;
    logic [W-1:0] out;

    int vectors    = 0;
    int miscompares = 0;
    int m_q        = 0;
    bit m_valid    = 1'b0;

    universal_shift_register #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .in   (in_d),
        .sel  (sel),
        .sinr (sinr),
        .sinl (sinl),
        .out  (out)
    );

    always #5 clk = ~clk;

    // Model: value as an integer, updated from the inputs present at each rising edge.
    task automatic step(input bit r, input bit [1:0] s, input bit [W-1:0] d,
                        input bit sr, input bit sl);
        @(negedge clk);
        reset = r; sel = s; in_d = d; sinr = sr; sinl = sl;
        @(posedge clk);
        if (r) begin
            m_q = 0;
            m_valid = 1'b1;
        end else if (s == 2'd1) begin
            m_q = (m_q / 2) + (sr ? (1 << (W - 1)) : 0);
        end else if (s == 2'd2) begin
            m_q = ((m_q * 2) & MASK) + (sl ? 1 : 0);
        end else if (s == 2'd3) begin
            m_q = int'(d);
        end
        #1;
    endtask

    task automatic lit(input string name, input bit [W-1:0] exp);
        vectors++;
        if (out !== exp) begin
            miscompares++;
            $display("FAIL %s: out=%b expected=%b at %0t", name, out, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model once reset has defined the register.
    always @(negedge clk) begin
        if (m_valid) begin
            vectors++;
            if (out !== W'(m_q)) begin
                miscompares++;
                $display("FAIL model: out=%b expected=%b at %0t", out, W'(m_q), $time);
            end
        end
    end

    initial begin
        // Reset overrides a parallel load and holds the register at zero.
        step(1, 2'b11, 4'b1111, 1, 1); lit("reset", 4'b0000);
        step(1, 2'b11, 4'b1111, 1, 1); lit("reset_held1", 4'b0000);
        step(1, 2'b01, 4'b1111, 1, 1); lit("reset_held2", 4'b0000);

        // Load then hold.
        step(0, 2'b11, 4'b0101, 0, 0); lit("load", 4'b0101);
        for (int i = 0; i < 3; i++) begin
            step(0, 2'b00, 4'b1111, 1, 1); lit("hold", 4'b0101);
        end

        // Shift right with sinr=1.
        step(0, 2'b01, 4'b0000, 1, 0); lit("shr1", 4'b1010);
        step(0, 2'b01, 4'b0000, 1, 0); lit("shr2", 4'b1101);
        step(0, 2'b01, 4'b0000, 1, 0); lit("shr3", 4'b1110);
        step(0, 2'b01, 4'b0000, 1, 0); lit("shr4", 4'b1111);

        // Shift left with sinl=0.
        step(0, 2'b11, 4'b0101, 0, 0); lit("reload", 4'b0101);
        step(0, 2'b10, 4'b0000, 1, 0); lit("shl1", 4'b1010);
        step(0, 2'b10, 4'b0000, 1, 0); lit("shl2", 4'b0100);
        step(0, 2'b10, 4'b0000, 1, 0); lit("shl3", 4'b1000);
        step(0, 2'b10, 4'b0000, 1, 0); lit("shl4", 4'b0000);

        // Reset in the middle of a shift sequence.
        step(0, 2'b11, 4'b1010, 0, 0); lit("load_a", 4'b1010);
        step(0, 2'b01, 4'b0000, 1, 0); lit("mid_shr", 4'b1101);
        step(1, 2'b01, 4'b0000, 1, 0); lit("mid_reset", 4'b0000);
        step(0, 2'b01, 4'b0000, 1, 0); lit("after_reset", 4'b1000);

        // Mixed modes on successive edges.
        step(0, 2'b11, 4'b0101, 1, 0); lit("mix_load", 4'b0101);
        step(0, 2'b01, 4'b0101, 1, 0); lit("mix_shr", 4'b1010);
        step(0, 2'b10, 4'b0101, 1, 0); lit("mix_shl", 4'b0100);
        step(0, 2'b00, 4'b0101, 1, 0); lit("mix_hold", 4'b0100);

        // Reset pulse between edges must not disturb the register.
        reset = 1'b1;
        #2;
        lit("async_pulse", 4'b0100);
        reset = 1'b0;

        // Random operations.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
                 W'($urandom), 1'($urandom), 1'($urandom));
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
